// File: rtl/periph_reg_target.sv
// periph_reg_target: req/gnt/r_valid peripheral target with byte-enable scratch regs, cycle counter and access counter
module periph_reg_target #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int BE_WIDTH     = DATA_WIDTH / 8,
   parameter int OFFSET_WIDTH = 10,
   parameter int NUM_REGS     = 4,
   parameter int WAIT_CYCLES  = 0
) (
   input  logic                  clk,
   input  logic                  rst_ni,
   input  logic                  data_req_i,
   input  logic [ADDR_WIDTH-1:0] data_add_i,
   input  logic                  data_wen_i,
   input  logic [DATA_WIDTH-1:0] data_wdata_i,
   input  logic [BE_WIDTH-1:0]   data_be_i,
   output logic                  data_gnt_o,
   output logic                  data_r_valid_o,
   output logic [DATA_WIDTH-1:0] data_r_rdata_o,
   output logic                  data_r_opc_o
);
   localparam int WW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int IW = OFFSET_WIDTH - 2;
   logic [WW-1:0]         wait_cnt;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [DATA_WIDTH-1:0] cycle_cnt, acc_cnt, rd_reg, rdata_d;
   logic [IW-1:0]         idx;
   logic                  is_reg, is_cyc, is_acc, err, wr, unused_add;
   assign idx        = data_add_i[OFFSET_WIDTH-1:2];
   assign unused_add = ^{data_add_i[ADDR_WIDTH-1:OFFSET_WIDTH], data_add_i[1:0]};
   assign data_gnt_o = data_req_i & (wait_cnt == WW'(WAIT_CYCLES));
   assign wr         = data_gnt_o & ~data_wen_i;
   assign is_reg     = idx < IW'(NUM_REGS);
   assign is_cyc     = idx == IW'(NUM_REGS);
   assign is_acc     = idx == IW'(NUM_REGS + 1);
   assign err        = is_cyc ? ~data_wen_i : ~(is_reg | is_acc);
   assign rdata_d    = (err | ~data_wen_i) ? '0 : is_reg ? rd_reg : is_cyc ? cycle_cnt : acc_cnt;
   always_comb begin
      rd_reg = '0;
      for (int r = 0; r < NUM_REGS; r++)
         if (idx == IW'(r)) rd_reg = regs[r];
   end
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         wait_cnt       <= '0;
         cycle_cnt      <= '0;
         acc_cnt        <= '0;
         data_r_valid_o <= 1'b0;
         data_r_rdata_o <= '0;
         data_r_opc_o   <= 1'b0;
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      end else begin
         wait_cnt       <= (data_gnt_o | ~data_req_i) ? '0 : wait_cnt + 1'b1;
         cycle_cnt      <= cycle_cnt + 1'b1;
         if (data_gnt_o) acc_cnt <= (is_acc & ~data_wen_i) ? '0 : acc_cnt + 1'b1;
         data_r_valid_o <= data_gnt_o;
         data_r_rdata_o <= data_gnt_o ? rdata_d : '0;
         data_r_opc_o   <= data_gnt_o & err;
         for (int r = 0; r < NUM_REGS; r++)
            for (int b = 0; b < BE_WIDTH; b++)
               if (wr & (idx == IW'(r)) & data_be_i[b]) regs[r][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
   end
endmodule

// File: tb/tb_periph_reg_target.sv
// tb_periph_reg_target: directed bench for a zero-wait and a three-wait-state instance
module tb_periph_reg_target;
   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req0 = 1'b0, req3 = 1'b0;
   logic [31:0] add = '0, wdata = '0;
   logic        wen = 1'b1;
   logic [3:0]  be = '0;
   logic        gnt0, rv0, opc0, gnt3, rv3, opc3;
   logic [31:0] rdata0, rdata3;
   int          errors = 0, checks = 0;

   always #5 clk = ~clk;

   periph_reg_target #(.WAIT_CYCLES(0)) u0 (
      .clk(clk), .rst_ni(rst_ni), .data_req_i(req0), .data_add_i(add), .data_wen_i(wen),
      .data_wdata_i(wdata), .data_be_i(be), .data_gnt_o(gnt0), .data_r_valid_o(rv0),
      .data_r_rdata_o(rdata0), .data_r_opc_o(opc0));

   periph_reg_target #(.WAIT_CYCLES(3)) u3 (
      .clk(clk), .rst_ni(rst_ni), .data_req_i(req3), .data_add_i(add), .data_wen_i(wen),
      .data_wdata_i(wdata), .data_be_i(be), .data_gnt_o(gnt3), .data_r_valid_o(rv3),
      .data_r_rdata_o(rdata3), .data_r_opc_o(opc3));

   task automatic acc0(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] b,
                       output logic g, output logic rv, output logic [31:0] rd, output logic op);
      @(negedge clk);
      add = a; wen = w; wdata = d; be = b; req0 = 1'b1;
      #1 g = gnt0;
      @(posedge clk);
      #1 rv = rv0; rd = rdata0; op = opc0;
   endtask

   task automatic acc3(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] b,
                       output int st, output logic early, output logic rv, output logic [31:0] rd,
                       output logic op);
      st = 0; early = 1'b0;
      @(negedge clk);
      add = a; wen = w; wdata = d; be = b; req3 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (gnt3) break;
         st++;
         early |= rv3;
         @(negedge clk);
      end
      @(posedge clk);
      #1 rv = rv3; rd = rdata3; op = opc3;
      @(negedge clk) req3 = 1'b0;
   endtask

   task automatic idle();
      @(negedge clk);
      req0 = 1'b0; req3 = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rv0 !== 1'b0 || rv3 !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b/%b exp=0/0", rv0, rv3); end
      checks++; if (rdata0 !== 32'h0 || opc0 !== 1'b0) begin errors++; $display("FAIL reset_rdata got=%h/%b exp=0/0", rdata0, opc0); end
      checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt got=%b exp=0", gnt0); end
      @(negedge clk) rst_ni = 1'b1;
   endtask

   task automatic test_basic();
      logic g, rv, op; logic [31:0] rd;
      acc0(32'h0, 1'b1, 32'h0, 4'h0, g, rv, rd, op);
      checks++; if (rd !== 32'h0 || op !== 1'b0) begin errors++; $display("FAIL reg0_init got=%h/%b exp=0/0", rd, op); end
      acc0(32'h0, 1'b0, 32'hDEADBEEF, 4'hF, g, rv, rd, op);
      checks++; if (g !== 1'b1) begin errors++; $display("FAIL wr_gnt got=%b exp=1", g); end
      checks++; if (rv !== 1'b1 || rd !== 32'h0 || op !== 1'b0) begin errors++; $display("FAIL wr_resp got=%b/%h/%b exp=1/0/0", rv, rd, op); end
      acc0(32'h0, 1'b1, 32'h0, 4'h0, g, rv, rd, op);
      checks++; if (g !== 1'b1) begin errors++; $display("FAIL rd_gnt got=%b exp=1", g); end
      checks++; if (rv !== 1'b1 || rd !== 32'hDEADBEEF || op !== 1'b0) begin errors++; $display("FAIL rd_resp got=%b/%h/%b exp=1/deadbeef/0", rv, rd, op); end
      idle();
      checks++; if (rv0 !== 1'b0 || rdata0 !== 32'h0) begin errors++; $display("FAIL rvalid_drop got=%b/%h exp=0/0", rv0, rdata0); end
   endtask

   task automatic test_byte_en();
      logic g, rv, op; logic [31:0] rd;
      acc0(32'h4, 1'b0, 32'h11223344, 4'hF, g, rv, rd, op);
      acc0(32'h4, 1'b0, 32'hAABBCCDD, 4'b0101, g, rv, rd, op);
      acc0(32'h4, 1'b1, 32'h0, 4'h0, g, rv, rd, op);
      checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL be_merge got=%h exp=11bb33dd", rd); end
      acc0(32'h4, 1'b0, 32'hFFFFFFFF, 4'h0, g, rv, rd, op);
      checks++; if (rv !== 1'b1 || op !== 1'b0) begin errors++; $display("FAIL be0_resp got=%b/%b exp=1/0", rv, op); end
      acc0(32'h4, 1'b1, 32'h0, 4'h0, g, rv, rd, op);
      checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL be0_nochange got=%h exp=11bb33dd", rd); end
      idle();
   endtask

   task automatic test_back_to_back();
      logic g, rv, op; logic [31:0] rd;
      acc0(32'h8, 1'b0, 32'h00000055, 4'hF, g, rv, rd, op);
      acc0(32'h8, 1'b1, 32'h0, 4'h0, g, rv, rd, op);
      checks++; if (rv !== 1'b1 || rd !== 32'h55) begin errors++; $display("FAIL b2b_reg2 got=%b/%h exp=1/55", rv, rd); end
      acc0(32'hC, 1'b0, 32'h00000066, 4'hF, g, rv, rd, op);
      acc0(32'hC, 1'b1, 32'h0, 4'h0, g, rv, rd, op);
      checks++; if (rv !== 1'b1 || rd !== 32'h66) begin errors++; $display("FAIL b2b_reg3 got=%b/%h exp=1/66", rv, rd); end
      acc0(32'h1020_4008, 1'b1, 32'h0, 4'h0, g, rv, rd, op);
      checks++; if (rd !== 32'h55) begin errors++; $display("FAIL upper_addr_ignored got=%h exp=55", rd); end
      idle();
   endtask

   task automatic test_errors();
      logic g, rv, op; logic [31:0] rd;
      acc0(32'h18, 1'b1, 32'h0, 4'h0, g, rv, rd, op);
      checks++; if (g !== 1'b1 || rv !== 1'b1 || op !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_rd_unmapped got=%b/%b/%b/%h exp=1/1/1/0", g, rv, op, rd); end
      acc0(32'h10, 1'b0, 32'h12345678, 4'hF, g, rv, rd, op);
      checks++; if (op !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_wr_cyc got=%b/%h exp=1/0", op, rd); end
      acc0(32'h3FC, 1'b0, 32'hCAFEF00D, 4'hF, g, rv, rd, op);
      checks++; if (op !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_wr_unmapped got=%b/%h exp=1/0", op, rd); end
      acc0(32'h0, 1'b1, 32'h0, 4'h0, g, rv, rd, op);
      checks++; if (rd !== 32'hDEADBEEF || op !== 1'b0) begin errors++; $display("FAIL err_nochange got=%h/%b exp=deadbeef/0", rd, op); end
      idle();
   endtask

   task automatic test_acc_cnt();
      logic g, rv, op; logic [31:0] rd;
      acc0(32'h14, 1'b0, 32'hFFFFFFFF, 4'hF, g, rv, rd, op);
      checks++; if (op !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL acc_clear_resp got=%b/%h exp=0/0", op, rd); end
      for (int i = 0; i < 5; i++) acc0(32'h0, 1'b1, 32'h0, 4'h0, g, rv, rd, op);
      acc0(32'h14, 1'b1, 32'h0, 4'h0, g, rv, rd, op);
      checks++; if (rd !== 32'd5 || op !== 1'b0) begin errors++; $display("FAIL acc_five got=%0d/%b exp=5/0", rd, op); end
      acc0(32'h14, 1'b0, 32'h0, 4'h0, g, rv, rd, op);
      acc0(32'h14, 1'b1, 32'h0, 4'h0, g, rv, rd, op);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL acc_after_clear got=%0d exp=0", rd); end
      acc0(32'h14, 1'b1, 32'h0, 4'h0, g, rv, rd, op);
      checks++; if (rd !== 32'd1) begin errors++; $display("FAIL acc_incr got=%0d exp=1", rd); end
      idle();
   endtask

   task automatic test_cycle_cnt();
      logic g, rv, op; logic [31:0] c1, c2, c3, c4;
      acc0(32'h10, 1'b1, 32'h0, 4'h0, g, rv, c1, op);
      checks++; if (op !== 1'b0) begin errors++; $display("FAIL cyc_rd_opc got=%b exp=0", op); end
      repeat (6) idle();
      acc0(32'h10, 1'b1, 32'h0, 4'h0, g, rv, c2, op);
      checks++; if (c2 - c1 !== 32'd7) begin errors++; $display("FAIL cyc_diff7 got=%0d exp=7", c2 - c1); end
      acc0(32'h10, 1'b1, 32'h0, 4'h0, g, rv, c3, op);
      acc0(32'h10, 1'b1, 32'h0, 4'h0, g, rv, c4, op);
      checks++; if (c4 - c3 !== 32'd1) begin errors++; $display("FAIL cyc_diff1 got=%0d exp=1", c4 - c3); end
      idle();
   endtask

   task automatic test_wait_states();
      int st; logic early, rv, op, g1, g2, g3, ra, rb; logic [31:0] rd;
      acc3(32'h0, 1'b1, 32'h0, 4'h0, st, early, rv, rd, op);
      checks++; if (st !== 3) begin errors++; $display("FAIL ws_stalls got=%0d exp=3", st); end
      checks++; if (early !== 1'b0 || rv !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL ws_resp got=%b/%b/%h exp=0/1/0", early, rv, rd); end
      @(negedge clk);
      add = 32'h0; wen = 1'b1; req3 = 1'b1;
      #1 g1 = gnt3;
      @(negedge clk);
      #1 g2 = gnt3;
      @(negedge clk) req3 = 1'b0;
      #1 g3 = gnt3;
      @(posedge clk);
      #1 ra = rv3;
      @(posedge clk);
      #1 rb = rv3;
      checks++; if ({g1, g2, g3} !== 3'b000 || {ra, rb} !== 2'b00) begin errors++; $display("FAIL ws_abort got=%b%b%b/%b%b exp=000/00", g1, g2, g3, ra, rb); end
      acc3(32'h0, 1'b0, 32'h12345678, 4'hF, st, early, rv, rd, op);
      checks++; if (st !== 3 || rv !== 1'b1 || op !== 1'b0) begin errors++; $display("FAIL ws_after_abort got=%0d/%b/%b exp=3/1/0", st, rv, op); end
      acc3(32'h14, 1'b1, 32'h0, 4'h0, st, early, rv, rd, op);
      checks++; if (rd !== 32'd2) begin errors++; $display("FAIL ws_acc_cnt got=%0d exp=2", rd); end
      acc3(32'h0, 1'b1, 32'h0, 4'h0, st, early, rv, rd, op);
      checks++; if (rd !== 32'h12345678 || st !== 3) begin errors++; $display("FAIL ws_reg0 got=%h/%0d exp=12345678/3", rd, st); end
   endtask

   task automatic test_reset_mid();
      logic g, rv, op, r1, r2; logic [31:0] rd;
      acc0(32'h0, 1'b1, 32'h0, 4'h0, g, rv, rd, op);
      rst_ni = 1'b0; req0 = 1'b0;
      #1;
      checks++; if (rv0 !== 1'b0 || rdata0 !== 32'h0) begin errors++; $display("FAIL rst_mid_drop got=%b/%h exp=0/0", rv0, rdata0); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_ni = 1'b1;
      @(posedge clk);
      #1 r1 = rv0;
      acc0(32'h10, 1'b1, 32'h0, 4'h0, g, r2, rd, op);
      checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL rst_no_rvalid got=%b exp=0", r1); end
      checks++; if (rd !== 32'd1 || op !== 1'b0) begin errors++; $display("FAIL rst_cyc got=%0d/%b exp=1/0", rd, op); end
      acc0(32'h0, 1'b1, 32'h0, 4'h0, g, rv, rd, op);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_reg0 got=%h exp=0", rd); end
      acc0(32'h4, 1'b1, 32'h0, 4'h0, g, rv, rd, op);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_reg1 got=%h exp=0", rd); end
      acc0(32'h14, 1'b1, 32'h0, 4'h0, g, rv, rd, op);
      checks++; if (rd !== 32'd3) begin errors++; $display("FAIL rst_acc got=%0d exp=3", rd); end
      idle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_byte_en();
      test_back_to_back();
      test_errors();
      test_acc_cnt();
      test_cycle_cnt();
      test_wait_states();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
